// File: rtl/sfu_acc_array.sv
`timescale 1ns/1ps
// Special-function accumulator: folds KSIZE*KSIZE passes of IN_W*IN_W partial-sum vectors into an
// OUT_W*OUT_W saturating bank, then drains it over valid/ready. Define SFU_RELU_EN to clamp negatives on drain.
module sfu_acc_array #(
   parameter int COL     = 8,
   parameter int PSUM_BW = 16,
   parameter int ACC_BW  = 16,
   parameter int IN_W    = 6,
   parameter int KSIZE   = 3
) (
   input  logic                                                      clk,
   input  logic                                                      reset,
   input  logic                                                      start,
   input  logic                                                      in_valid,
   output logic                                                      in_ready,
   input  logic [COL*PSUM_BW-1:0]                                    in_data,
   output logic                                                      out_valid,
   input  logic                                                      out_ready,
   output logic [COL*ACC_BW-1:0]                                     out_data,
   output logic [$clog2((IN_W-KSIZE+1)*(IN_W-KSIZE+1))-1:0]          out_addr,
   output logic                                                      busy,
   output logic                                                      done
);

   localparam int OUT_W = IN_W - KSIZE + 1;
   localparam int NOUT  = OUT_W * OUT_W;
   localparam int AW    = $clog2(NOUT);
   localparam int KW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam int PW    = (IN_W > 1) ? $clog2(IN_W) : 1;

   typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

   state_t                     state;
   logic [KW-1:0]              kr, kc;
   logic [PW-1:0]              pr, pc;
   logic signed [ACC_BW-1:0]   bank [NOUT][COL];

   logic                       take;
   logic                       pix_ok;
   logic [AW-1:0]              pix_idx;
   logic                       last_beat;

   function automatic logic signed [ACC_BW-1:0] sat_add(input logic signed [ACC_BW-1:0] a,
                                                        input logic [PSUM_BW-1:0] p);
      logic [ACC_BW:0] s;
      s = {a[ACC_BW-1], a} + {{(ACC_BW+1-PSUM_BW){p[PSUM_BW-1]}}, p};
      if (s[ACC_BW] != s[ACC_BW-1])
         return s[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
      return s[ACC_BW-1:0];
   endfunction

   // Output pixel for the current beat: the input pixel shifted back by the kernel offset.
   always_comb begin
      int orow;
      int ocol;
      orow      = int'(pr) - int'(kr);
      ocol      = int'(pc) - int'(kc);
      pix_ok    = (orow >= 0) && (orow < OUT_W) && (ocol >= 0) && (ocol < OUT_W);
      pix_idx   = pix_ok ? AW'(orow * OUT_W + ocol) : '0;
      take      = (state == ACC) && in_valid;
      last_beat = (kr == KW'(KSIZE-1)) && (kc == KW'(KSIZE-1)) &&
                  (pr == PW'(IN_W-1)) && (pc == PW'(IN_W-1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if (state == IDLE && start) begin
            for (int a = 0; a < NOUT; a++)
               for (int c = 0; c < COL; c++)
                  bank[a][c] <= '0;
         end else if (take && pix_ok) begin
            for (int c = 0; c < COL; c++)
               bank[pix_idx][c] <= sat_add(bank[pix_idx][c], in_data[c*PSUM_BW +: PSUM_BW]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         kr        <= '0;
         kc        <= '0;
         pr        <= '0;
         pc        <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  kr       <= '0;
                  kc       <= '0;
                  pr       <= '0;
                  pc       <= '0;
                  out_addr <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ACC;
               end
            end
            ACC: begin
               if (take) begin
                  // pc is innermost, then pr, then kc, then kr
                  if (pc != PW'(IN_W-1)) begin
                     pc <= pc + 1'b1;
                  end else begin
                     pc <= '0;
                     if (pr != PW'(IN_W-1)) begin
                        pr <= pr + 1'b1;
                     end else begin
                        pr <= '0;
                        if (kc != KW'(KSIZE-1)) begin
                           kc <= kc + 1'b1;
                        end else begin
                           kc <= '0;
                           kr <= (kr == KW'(KSIZE-1)) ? '0 : kr + 1'b1;
                        end
                     end
                  end
                  if (last_beat) begin
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_addr  <= '0;
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_addr == AW'(NOUT-1)) begin
                     out_valid <= 1'b0;
                     out_addr  <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     out_addr <= out_addr + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      out_data = '0;
      for (int c = 0; c < COL; c++) begin
         logic signed [ACC_BW-1:0] v;
         v = bank[out_addr][c];
`ifdef SFU_RELU_EN
         if (v[ACC_BW-1])
            v = '0;
`endif
         out_data[c*ACC_BW +: ACC_BW] = v;
      end
   end

endmodule

// File: tb/tb_sfu_acc_array.sv
`timescale 1ns/1ps
// Scoreboard bench for sfu_acc_array: directed tiles push expected drain words, a monitor pops and compares.
module tb_sfu_acc_array;

   localparam int COL   = 8;
   localparam int PB    = 16;
   localparam int AB    = 16;
   localparam int BEATS = 324;
   localparam int NOUT  = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                in_valid;
   logic                in_ready;
   logic [COL*PB-1:0]   in_data;
   logic                out_valid;
   logic                out_ready;
   logic [COL*AB-1:0]   out_data;
   logic [3:0]          out_addr;
   logic                busy;
   logic                done;

   typedef struct {
      logic [3:0]        addr;
      logic [COL*AB-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   bit   bp     = 1'b0;

   sfu_acc_array dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [COL*AB-1:0] act, input logic [COL*AB-1:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Stimulus per mode; k = pass index (kr*3+kc), beat = k*36 + pixel
   function automatic logic [PB-1:0] beat_val(input int mode, input int beat, input int ch);
      int k;
      k = beat / 36;
      case (mode)
         0: return 16'd1;
         1: return PB'((k + 1) * (ch + 1));
         2: return (beat == 0)   ? 16'd5 : 16'd0;
         3: return (beat == 37)  ? 16'd7 : 16'd0;
         4: return (beat == 323) ? 16'd3 : 16'd0;
         5: return (beat == 4)   ? 16'd9 : 16'd0;
         6: return 16'h7000;
         default: return 16'h9000;
      endcase
   endfunction

   function automatic logic [AB-1:0] exp_val(input int mode, input int addr, input int ch);
      case (mode)
         0: return 16'd9;
         1: return AB'(45 * (ch + 1));
         2: return (addr == 0)  ? 16'd5 : 16'd0;
         3: return (addr == 0)  ? 16'd7 : 16'd0;
         4: return (addr == 15) ? 16'd3 : 16'd0;
         5: return 16'd0;
         6: return 16'h7FFF;
`ifdef SFU_RELU_EN
         default: return 16'h0000;
`else
         default: return 16'h8000;
`endif
      endcase
   endfunction

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops on every accepted drain word, and checks hold-stability while stalled
   initial begin
      logic              held;
      logic [3:0]        h_addr;
      logic [COL*AB-1:0] h_data;
      exp_t              e;
      held = 1'b0;
      h_addr = '0;
      h_data = '0;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (held) begin
               check_output("stall_addr", {{(COL*AB-4){1'b0}}, out_addr}, {{(COL*AB-4){1'b0}}, h_addr});
               check_output("stall_data", out_data, h_data);
            end
            if (out_ready) begin
               held = 1'b0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("[TB] FAIL unexpected_word: got addr %0d data %h expected none", out_addr, out_data);
               end else begin
                  e = exp_q.pop_front();
                  check_output("drain_addr", {{(COL*AB-4){1'b0}}, out_addr}, {{(COL*AB-4){1'b0}}, e.addr});
                  check_output("drain_data", out_data, e.data);
               end
            end else begin
               held   = 1'b1;
               h_addr = out_addr;
               h_data = out_data;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   task automatic push_expected(input int mode);
      exp_t e;
      for (int a = 0; a < NOUT; a++) begin
         e.addr = 4'(a);
         for (int c = 0; c < COL; c++)
            e.data[c*AB +: AB] = exp_val(mode, a, c);
         exp_q.push_back(e);
      end
   endtask

   task automatic do_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic apply_stimulus(input int mode, input bit rnd, input int start_at, input int abort_at);
      int beat;
      int cyc;
      beat = 0;
      cyc  = 0;
      while (beat < BEATS && beat != abort_at) begin
         @(posedge clk);
         #1;
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start    = (beat == start_at);
         for (int c = 0; c < COL; c++)
            in_data[c*PB +: PB] = beat_val(mode, beat, c);
         @(negedge clk);
         if (in_valid && in_ready)
            beat++;
         cyc++;
         if (cyc > 2000) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL feed_timeout: got %0d beats expected %0d", beat, BEATS);
            break;
         end
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (abort_at < 0) begin
         in_valid = 1'b1;
         @(negedge clk);
         check_output("in_ready_after_last", {{(COL*AB-1){1'b0}}, in_ready}, '0);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int cyc;
      cyc = 0;
      while (!done && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check_output("done_pulse", {{(COL*AB-1){1'b0}}, done}, 1);
      @(negedge clk);
      check_output("done_width", {{(COL*AB-1){1'b0}}, done}, '0);
      check_output("busy_after_done", {{(COL*AB-1){1'b0}}, busy}, '0);
      check_output("words_left", (COL*AB)'(exp_q.size()), '0);
   endtask

   task automatic run_tile(input int mode, input bit rnd, input int start_at);
      push_expected(mode);
      do_start();
      apply_stimulus(mode, rnd, start_at, -1);
      wait_done();
   endtask

   initial begin
      int dones;
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("rst_in_ready",  {{(COL*AB-1){1'b0}}, in_ready},  '0);
      check_output("rst_out_valid", {{(COL*AB-1){1'b0}}, out_valid}, '0);
      check_output("rst_busy",      {{(COL*AB-1){1'b0}}, busy},      '0);
      check_output("rst_done",      {{(COL*AB-1){1'b0}}, done},      '0);
      check_output("rst_out_addr",  {{(COL*AB-4){1'b0}}, out_addr},  '0);
      @(posedge clk);
      #1 reset = 1'b1;

      $display("[TB] directed tiles");
      for (int m = 0; m < 8; m++)
         run_tile(m, 1'b0, -1);

      $display("[TB] backpressure tile");
      bp = 1'b1;
      run_tile(0, 1'b1, -1);
      bp = 1'b0;

      $display("[TB] start during ACC");
      run_tile(0, 1'b0, 50);

      $display("[TB] abort at beat 100");
      do_start();
      apply_stimulus(0, 1'b0, -1, 100);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_output("abort_busy",     {{(COL*AB-1){1'b0}}, busy},     '0);
      check_output("abort_in_ready", {{(COL*AB-1){1'b0}}, in_ready}, '0);
      dones = 0;
      repeat (50) begin
         @(negedge clk);
         if (done)
            dones++;
      end
      check_output("abort_no_done", (COL*AB)'(dones), '0);

      $display("[TB] fresh tile after abort");
      run_tile(0, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
